// File: rtl/mem_line_responder_if.sv
// Cache-controller-to-memory line request/response bundle.
// The cache controller drives requests (master); the memory responder answers (slave).
interface mem_line_responder_if;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_req_rw;
  logic         mem_req_valid;
  logic [31:0]  mem_rsp_data;
  logic         mem_rsp_ready;

  modport master (
    output mem_req_addr, mem_req_data, mem_req_rw, mem_req_valid,
    input  mem_rsp_data, mem_rsp_ready
  );

  modport slave (
    input  mem_req_addr, mem_req_data, mem_req_rw, mem_req_valid,
    output mem_rsp_data, mem_rsp_ready
  );
endinterface

// File: rtl/mem_line_responder.sv
// Line-organised memory responder: 128-bit line writes with one ack, reads as four 32-bit beats.
// Optional MEM_RSP_CRITICAL_WORD_FIRST_EN returns the addressed word first, wrapping within the line.
module mem_line_responder #(
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_line_responder_if.slave  bus
);
  localparam int IW = $clog2(DEPTH_LINES);

`ifdef MEM_RSP_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WAIT, BEAT, WACK, DONE} state_t;

  state_t        state;
  logic [7:0]    wait_cnt;
  logic [1:0]    beat_cnt;
  logic [1:0]    start_q;
  logic [IW-1:0] idx_q;
  logic          rw_q;
  logic [127:0]  line_q;
  logic [31:0]   rsp_data;
  logic          rsp_ready;

  logic [127:0]  store [DEPTH_LINES];
  logic [127:0]  rd_line;
  logic          wr_en;
  logic          unused_addr;

  // Byte offset and bits above the index never select a line; higher addresses alias.
  assign unused_addr = ^{bus.mem_req_addr[31:4+IW], bus.mem_req_addr[1:0]};

  assign wr_en   = (state == WAIT) && (wait_cnt == '0) && rw_q;
  assign rd_line = store[idx_q];

  assign bus.mem_rsp_data  = rsp_data;
  assign bus.mem_rsp_ready = rsp_ready;

  function automatic logic [31:0] word_of(input logic [127:0] line, input logic [1:0] w);
    return line[{w, 5'd0} +: 32];
  endfunction

  // NOTE: the backing store has no reset; contents must survive rst_n and
  // a resettable array would not map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en) store[idx_q] <= line_q;
  end

  // The final response cycle doubles as the turnaround: the state is not IDLE
  // there, so the controller's still-held valid is ignored on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      beat_cnt  <= '0;
      start_q   <= '0;
      idx_q     <= '0;
      rw_q      <= 1'b0;
      line_q    <= '0;
      rsp_data  <= '0;
      rsp_ready <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first, so every path below only overrides
      // what it drives and data is zero whenever ready is low.
      rsp_ready <= 1'b0;
      rsp_data  <= '0;
      case (state)
        IDLE: begin
          if (bus.mem_req_valid) begin
            idx_q    <= bus.mem_req_addr[4 +: IW];
            start_q  <= CWF ? bus.mem_req_addr[3:2] : 2'b00;
            rw_q     <= bus.mem_req_rw;
            line_q   <= bus.mem_req_data;
            wait_cnt <= 8'(LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            rsp_ready <= 1'b1;
            if (rw_q) begin
              state <= WACK;
            end else begin
              rsp_data <= word_of(rd_line, start_q);
              beat_cnt <= 2'd1;
              state    <= BEAT;
            end
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        BEAT: begin
          rsp_ready <= 1'b1;
          rsp_data  <= word_of(rd_line, start_q + beat_cnt);
          beat_cnt  <= beat_cnt + 2'd1;
          if (beat_cnt == 2'd3) state <= DONE;
        end
        WACK:    state <= IDLE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
